// File: rtl/imem_pkg.sv
// Shared definitions for the multi-port instruction memory.
// Fill word, response bundle and address helper.
package imem_pkg;

  localparam logic [31:0] IMEM_NOP = 32'h00000013;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } fetch_rsp_t;

  function automatic logic [31:0] word_idx(
    input logic [31:0] addr
  );
    return addr >> 2;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with internal pointer.
// Search starts at the pointer; pointer moves past each winner.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);

  logic [IW-1:0] ptr;

  always_comb begin
    int   j;
    logic found;
    gnt    = '0;
    gnt_id = '0;
    j      = 0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (advance && !found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        gnt_id = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/imem_multiport.sv
// Instruction store shared by N fetch channels.
// One access per cycle: host load wins, else one arbitrated fetch.
module imem_multiport
  import imem_pkg::*;
#(
  parameter int N_CORES   = 4,
  parameter int DEPTH     = 256,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter     INIT_FILE = ""
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CORES-1:0]        fetch_req,
  input  logic [N_CORES*ADDR_W-1:0] fetch_addr,
  output logic [N_CORES-1:0]        fetch_gnt,
  output logic [N_CORES-1:0]        rsp_valid,
  output logic [N_CORES*DATA_W-1:0] rsp_data,
  output logic [N_CORES-1:0]        rsp_err,
  input  logic                      ld_we,
  input  logic [ADDR_W-1:0]         ld_addr,
  input  logic [DATA_W-1:0]         ld_data
);

  localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int XW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * 4);

  logic [DATA_W-1:0] mem [DEPTH];

  initial begin
    for (int w = 0; w < DEPTH; w++) begin
`ifdef IMEM_NOP_FILL
      mem[w] = DATA_W'(IMEM_NOP);
`else
      mem[w] = '0;
`endif
    end
  end

  logic [IW-1:0]     gnt_id;
  logic [ADDR_W-1:0] addr;
  logic [XW-1:0]     idx;
  logic [XW-1:0]     ld_idx;
  logic              good;
  logic              ld_ok;
  logic              pend;
  logic              pend_err;
  logic [IW-1:0]     pend_id;
  logic [DATA_W-1:0] data_q [N_CORES];

  rr_arbiter #(
    .N(N_CORES)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (fetch_req),
    .advance (rst_n & ~ld_we),
    .gnt     (fetch_gnt),
    .gnt_id  (gnt_id)
  );

  always_comb begin
    addr   = fetch_addr[gnt_id*ADDR_W +: ADDR_W];
    idx    = XW'(word_idx(32'(addr)));
    good   = (addr[1:0] == 2'b00) && (addr < LIMIT);
    ld_idx = XW'(word_idx(32'(ld_addr)));
    ld_ok  = ld_addr < LIMIT;
  end

  always_ff @(posedge clk) begin
    if (ld_we && ld_ok) begin
      mem[ld_idx] <= ld_data;
    end
  end

  // Word is captured at grant time; per-channel data holds between hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_err <= 1'b0;
      pend_id  <= '0;
      for (int k = 0; k < N_CORES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      pend <= |fetch_gnt;
      if (|fetch_gnt) begin
        pend_id         <= gnt_id;
        pend_err        <= ~good;
        data_q[gnt_id]  <= good ? mem[idx] : '0;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_err   = '0;
    rsp_data  = '0;
    for (int k = 0; k < N_CORES; k++) begin
      rsp_data[k*DATA_W +: DATA_W] = data_q[k];
      if (pend && int'(pend_id) == k) begin
        rsp_valid[k] = 1'b1;
        rsp_err[k]   = pend_err;
      end
    end
  end

endmodule

// File: tb/tb_imem_multiport.sv
// Scoreboard bench for imem_multiport (4 cores, 256 words).
// Driver checks grants and queues responses; monitor pops them.
module tb_imem_multiport;

  logic         clk;
  logic         rst_n;
  logic [3:0]   fetch_req;
  logic [127:0] fetch_addr;
  logic [3:0]   fetch_gnt;
  logic [3:0]   rsp_valid;
  logic [127:0] rsp_data;
  logic [3:0]   rsp_err;
  logic         ld_we;
  logic [31:0]  ld_addr;
  logic [31:0]  ld_data;

  imem_multiport #(
    .N_CORES (4),
    .DEPTH   (256),
    .DATA_W  (32),
    .ADDR_W  (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_gnt  (fetch_gnt),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          core;
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [256];
  int          cyc_n;
  int          checks;
  int          errors;

  initial cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic void set_addr(int core, logic [31:0] a);
    fetch_addr[core*32 +: 32] = a;
  endfunction

  function automatic void push(int core);
    exp_t        e;
    logic [31:0] a;
    a      = fetch_addr[core*32 +: 32];
    e.core = core;
    e.err  = (a[1:0] != 2'b00) || (a >= 32'h400);
    e.data = e.err ? 32'h0 : model[a[9:2]];
    e.cyc  = cyc_n;
    q.push_back(e);
  endfunction

  // One fetch cycle: drive requests, check grant at negedge.
  task automatic step(input logic [3:0] req,
                      input logic [3:0] exp_gnt,
                      input bit do_push = 1'b1);
    fetch_req = req;
    @(negedge clk);
    checks++;
    if (fetch_gnt !== exp_gnt) begin
      errors++;
      $display("FAIL gnt t=%0t got=%b want=%b", $time, fetch_gnt, exp_gnt);
    end
    if (do_push) begin
      for (int k = 0; k < 4; k++) begin
        if (exp_gnt[k]) push(k);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    checks++;
    if (fetch_gnt !== 4'b0000) begin
      errors++;
      $display("FAIL ld_gnt t=%0t got=%b want=0000", $time, fetch_gnt);
    end
    if (a < 32'h400) model[a[9:2]] = d;
    @(posedge clk);
    #1;
    ld_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (fetch_gnt !== 4'b0 || rsp_valid !== 4'b0 ||
        rsp_err !== 4'b0 || rsp_data !== 128'b0) begin
      errors++;
      $display("FAIL %s gnt=%b valid=%b err=%b data=%h want all zero",
               tag, fetch_gnt, rsp_valid, rsp_err, rsp_data);
    end
  endtask

  // Monitor: every response must match the queue head, one cycle late.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc_n - 1) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_rsp core=%0d got=none want=valid", e.core);
    end
    if (rsp_valid !== 4'b0) begin
      checks++;
      if (q.size() == 0 || q[0].cyc != cyc_n - 1) begin
        errors++;
        $display("FAIL unexpected_rsp valid=%b want=none", rsp_valid);
      end else begin
        e = q.pop_front();
        if (rsp_valid !== (4'b1 << e.core) ||
            rsp_err !== (4'(e.err) << e.core) ||
            rsp_data[e.core*32 +: 32] !== e.data) begin
          errors++;
          $display("FAIL rsp core=%0d valid=%b err=%b data=%h want err=%b data=%h",
                   e.core, rsp_valid, rsp_err,
                   rsp_data[e.core*32 +: 32], e.err, e.data);
        end
      end
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    fetch_req  = 4'b1111;
    fetch_addr = '0;
    ld_we      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    for (int i = 0; i < 256; i++) model[i] = 32'h0;

    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    fetch_req = 4'b0000;

    ld(32'h000, 32'h00500093);
    ld(32'h004, 32'h00800113);
    ld(32'h008, 32'h01000193);
    ld(32'h00C, 32'h11111111);
    ld(32'h3FC, 32'hDEADBEEF);

    // All cores requesting continuously: strict rotation.
    for (int k = 0; k < 4; k++) set_addr(k, 32'(k * 4));
    for (int r = 0; r < 2; r++) begin
      step(4'b1111, 4'b0001);
      step(4'b1111, 4'b0010);
      step(4'b1111, 4'b0100);
      step(4'b1111, 4'b1000);
    end

    // Single core, back-to-back program words.
    set_addr(0, 32'h0);
    step(4'b0001, 4'b0001);
    set_addr(0, 32'h4);
    step(4'b0001, 4'b0001);
    set_addr(0, 32'h8);
    step(4'b0001, 4'b0001);

    // Pointer at 2: core 3 before core 1.
    step(4'b0010, 4'b0010);
    step(4'b1010, 4'b1000);
    step(4'b0010, 4'b0010);
    step(4'b1111, 4'b0100);

    // Load holds off pending fetches; new word visible next cycle.
    set_addr(0, 32'h10);
    set_addr(2, 32'h10);
    fetch_req = 4'b0101;
    ld(32'h010, 32'hAAAA0001);
    ld(32'h014, 32'hBBBB0002);
    ld(32'h010, 32'hCCCC0003);
    step(4'b0101, 4'b0001);
    step(4'b0101, 4'b0100);

    // Misaligned and out-of-range fetches, then the last word.
    set_addr(1, 32'h402);
    set_addr(3, 32'h400);
    step(4'b1010, 4'b1000);
    step(4'b1010, 4'b0010);
    set_addr(2, 32'h3FC);
    step(4'b0100, 4'b0100);

    // Out-of-range load must not wrap onto word 0.
    fetch_req = 4'b0000;
    ld(32'h400, 32'hBAD0BAD0);
    set_addr(0, 32'h0);
    step(4'b0001, 4'b0001);

    // Reset right after a grant drops its response.
    step(4'b0100, 4'b0100, 1'b0);
    rst_n     = 1'b0;
    fetch_req = 4'b1111;
    @(negedge clk);
    check_reset_outputs("reset_drop");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b1010, 4'b0010);

    fetch_req = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
